// File: rtl/ofs_plat_prim_fifo2_rr_mux.sv
`default_nettype none
// =============================================================================
// Module  : ofs_plat_prim_fifo2_rr_mux
// Brief   : Per-source FIFO2 skid buffers merged by a packet-locked round-robin
//           arbiter into a single FIFO2-style output stage.
// Revision: 1.0
// =============================================================================
module ofs_plat_prim_fifo2_rr_mux #(
   parameter int N_SOURCES   = 4,
   parameter int N_DATA_BITS = 32,
   localparam int SRC_W      = $clog2((N_SOURCES > 1) ? N_SOURCES : 2)
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [N_SOURCES-1:0][N_DATA_BITS-1:0] in_data,
   input  logic [N_SOURCES-1:0]                  in_eop,
   input  logic [N_SOURCES-1:0]                  in_enq_en,
   output logic [N_SOURCES-1:0]                  in_notFull,
   output logic [N_DATA_BITS-1:0]                out_first,
   output logic                                  out_eop,
   output logic [SRC_W-1:0]                      out_src,
   output logic                                  out_notEmpty,
   input  logic                                  out_deq_en
);

   localparam int BW = N_DATA_BITS + 1;   // {eop, data}
   localparam int OW = SRC_W + BW;        // {src, eop, data}

   logic [N_SOURCES-1:0]          src_v1;
   logic [N_SOURCES-1:0][BW-1:0]  src_head;

   logic                          grant_any;
   logic [SRC_W-1:0]              grant_src;
   logic [BW-1:0]                 grant_head;
   logic                          move;

   logic                          lock_vld_q, lock_vld_d;
   logic [SRC_W-1:0]              lock_src_q, lock_src_d;
   logic [SRC_W-1:0]              rr_q, rr_d;

   logic                          out_v0_q, out_v0_d, out_v1_q, out_v1_d;
   logic [OW-1:0]                 out_d0_q, out_d0_d, out_d1_q, out_d1_d;
   logic [OW-1:0]                 out_beat;

   // Slot 1 is the head, slot 0 the skid entry; notFull reflects slot 0 only.
   for (genvar s = 0; s < N_SOURCES; s++) begin : g_src
      logic          v0_q, v0_d, v1_q, v1_d;
      logic [BW-1:0] d0_q, d0_d, d1_q, d1_d;
      logic          enq, deq;
      logic [BW-1:0] enq_beat;

      assign enq        = in_enq_en[s];
      assign enq_beat   = {in_eop[s], in_data[s]};
      assign deq        = move && (grant_src == SRC_W'(s));
      assign src_v1[s]   = v1_q;
      assign src_head[s] = d1_q;
      assign in_notFull[s] = !v0_q;

      always_comb begin
         v0_d = v0_q;
         v1_d = v1_q;
         d0_d = d0_q;
         d1_d = d1_q;
         if (deq || !v1_q) begin
            v1_d = v0_q | enq;
            d1_d = v0_q ? d0_q : enq_beat;
            v0_d = v0_q & enq;
            d0_d = enq_beat;
         end else if (enq) begin
            v0_d = 1'b1;
            d0_d = enq_beat;
         end
      end

      always_ff @(posedge clk) begin
         d0_q <= d0_d;
         d1_q <= d1_d;
         if (!reset_n) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
         end else begin
            v0_q <= v0_d;
            v1_q <= v1_d;
         end
         if (reset_n) begin
            assert (!(enq && v0_q)) else $fatal(1, "enqueue to full source buffer");
         end
      end
   end

   // A held lock pins the grant to its source even while that source is empty.
   always_comb begin
      int idx;
      idx       = 0;
      grant_any = 1'b0;
      grant_src = lock_src_q;
      if (lock_vld_q) begin
         grant_any = src_v1[lock_src_q];
      end else begin
         for (int i = N_SOURCES - 1; i >= 0; i--) begin
            idx = int'(rr_q) + i;
            if (idx >= N_SOURCES) idx = idx - N_SOURCES;
            if (src_v1[idx]) begin
               grant_any = 1'b1;
               grant_src = SRC_W'(idx);
            end
         end
      end
   end

   assign grant_head = src_head[grant_src];
   assign move       = grant_any && (!out_v0_q || out_deq_en);
   assign out_beat   = {grant_src, grant_head};

   always_comb begin
      lock_vld_d = lock_vld_q;
      lock_src_d = lock_src_q;
      rr_d       = rr_q;
      if (move) begin
         if (grant_head[BW-1]) begin
            lock_vld_d = 1'b0;
            rr_d       = (int'(grant_src) == N_SOURCES - 1) ? '0 : grant_src + SRC_W'(1);
         end else begin
            lock_vld_d = 1'b1;
            lock_src_d = grant_src;
         end
      end
   end

   always_comb begin
      out_v0_d = out_v0_q;
      out_v1_d = out_v1_q;
      out_d0_d = out_d0_q;
      out_d1_d = out_d1_q;
      if (out_deq_en || !out_v1_q) begin
         out_v1_d = out_v0_q | move;
         out_d1_d = out_v0_q ? out_d0_q : out_beat;
         out_v0_d = out_v0_q & move;
         out_d0_d = out_beat;
      end else if (move) begin
         out_v0_d = 1'b1;
         out_d0_d = out_beat;
      end
   end

   always_ff @(posedge clk) begin
      out_d0_q <= out_d0_d;
      out_d1_q <= out_d1_d;
      if (!reset_n) begin
         out_v0_q   <= 1'b0;
         out_v1_q   <= 1'b0;
         lock_vld_q <= 1'b0;
         lock_src_q <= '0;
         rr_q       <= '0;
      end else begin
         out_v0_q   <= out_v0_d;
         out_v1_q   <= out_v1_d;
         lock_vld_q <= lock_vld_d;
         lock_src_q <= lock_src_d;
         rr_q       <= rr_d;
      end
      if (reset_n) begin
         assert (!(out_deq_en && !out_v1_q)) else $fatal(1, "dequeue from empty output stage");
      end
   end

   assign out_notEmpty = out_v1_q;
   assign {out_src, out_eop, out_first} = out_d1_q;

endmodule
`default_nettype wire

// File: tb/tb_ofs_plat_prim_fifo2_rr_mux.sv
`default_nettype none
// =============================================================================
// Module  : tb_ofs_plat_prim_fifo2_rr_mux
// Brief   : Directed self-checking bench for the packet-locked RR FIFO2 mux.
// Revision: 1.0
// =============================================================================
module tb_ofs_plat_prim_fifo2_rr_mux;

   localparam int NS = 4;
   localparam int W  = 32;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic [NS-1:0][W-1:0] in_data = '0;
   logic [NS-1:0]        in_eop = '0;
   logic [NS-1:0]        in_enq_en = '0;
   logic [NS-1:0]        in_notFull;
   logic [W-1:0]         out_first;
   logic                 out_eop;
   logic [1:0]           out_src;
   logic                 out_notEmpty;
   logic                 out_deq_en = 1'b0;

   always #5 clk = ~clk;

   ofs_plat_prim_fifo2_rr_mux #(.N_SOURCES(NS), .N_DATA_BITS(W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_data      (in_data),
      .in_eop       (in_eop),
      .in_enq_en    (in_enq_en),
      .in_notFull   (in_notFull),
      .out_first    (out_first),
      .out_eop      (out_eop),
      .out_src      (out_src),
      .out_notEmpty (out_notEmpty),
      .out_deq_en   (out_deq_en)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Every beat consumed at the output, in order.
   logic [W-1:0] cap_data [0:255];
   logic [1:0]   cap_src  [0:255];
   logic         cap_eop  [0:255];
   int           cap_cyc  [0:255];
   int           cap_cnt = 0;
   always @(negedge clk) begin
      if (reset_n && out_notEmpty && out_deq_en && cap_cnt < 256) begin
         cap_data[cap_cnt] <= out_first;
         cap_src[cap_cnt]  <= out_src;
         cap_eop[cap_cnt]  <= out_eop;
         cap_cyc[cap_cnt]  <= cyc;
         cap_cnt           <= cap_cnt + 1;
      end
   end

   // Pending beats per source, {eop, data}.
   logic [W:0] sq [NS][0:31];
   int         sh [NS];
   int         st [NS];
   logic       deq_mode = 1'b0;

   task automatic push(int s, logic eop, logic [W-1:0] d);
      sq[s][st[s]] = {eop, d};
      st[s]++;
   endtask

   task automatic tick();
      for (int s = 0; s < NS; s++) begin
         in_enq_en[s] = 1'b0;
         if (reset_n && sh[s] != st[s] && in_notFull[s]) begin
            {in_eop[s], in_data[s]} = sq[s][sh[s]];
            in_enq_en[s] = 1'b1;
            sh[s]++;
         end
      end
      out_deq_en = deq_mode && reset_n && out_notEmpty;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(int n);
      reset_n    = 1'b0;
      deq_mode   = 1'b0;
      out_deq_en = 1'b0;
      for (int s = 0; s < NS; s++) begin
         sh[s] = 0;
         st[s] = 0;
      end
      repeat (n) begin
         in_enq_en = NS'($urandom);
         in_eop    = NS'($urandom);
         for (int s = 0; s < NS; s++) in_data[s] = $urandom;
         @(posedge clk);
         #1;
      end
      in_enq_en = '0;
      reset_n   = 1'b1;
   endtask

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_caps(int n, int budget, string tag);
      int k = 0;
      while (cap_cnt < n && k < budget) begin
         tick();
         k++;
      end
      chk(tag, 64'(cap_cnt >= n), 64'd1);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int e_src  [11] = '{0, 1, 1, 1, 3, 0, 3, 0, 3, 0, 3};
      int e_data [11] = '{'h000, 'h100, 'h101, 'h102, 'h300, 'h001,
                          'h301, 'h002, 'h302, 'h003, 'h303};
      int e_eop  [11] = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};

      // Reset with random enqueue traffic
      do_reset(3);
      chk("rst_notFull", 64'(in_notFull), 64'hF);
      chk("rst_notEmpty", 64'(out_notEmpty), 64'd0);
      tick();
      chk("rst_idle_notEmpty", 64'(out_notEmpty), 64'd0);

      // Single beat from source 2: visible two cycles after enqueue
      deq_mode = 1'b1;
      push(2, 1'b1, 32'hA5);
      base = cap_cnt;
      tick();
      chk("sb_t1_notEmpty", 64'(out_notEmpty), 64'd0);
      tick();
      chk("sb_t2_notEmpty", 64'(out_notEmpty), 64'd1);
      chk("sb_t2_first", 64'(out_first), 64'hA5);
      chk("sb_t2_src", 64'(out_src), 64'd2);
      chk("sb_t2_eop", 64'(out_eop), 64'd1);
      tick();
      chk("sb_t3_notEmpty", 64'(out_notEmpty), 64'd0);
      chk("sb_count", 64'(cap_cnt - base), 64'd1);

      // Round-robin fairness with single-beat packets
      do_reset(2);
      deq_mode = 1'b1;
      for (int q = 0; q < 4; q++)
         for (int s = 0; s < NS; s++) push(s, 1'b1, 32'(s * 256 + q));
      base = cap_cnt;
      wait_caps(base + 16, 60, "rr_timeout");
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("rr_src[%0d]", i), 64'(cap_src[base+i]), 64'(i % 4));
         chk($sformatf("rr_data[%0d]", i), 64'(cap_data[base+i]), 64'((i % 4) * 256 + i / 4));
         if (i > 0)
            chk($sformatf("rr_gap[%0d]", i), 64'(cap_cyc[base+i] - cap_cyc[base+i-1]), 64'd1);
      end

      // Packet lock: source 1 three-beat packet with a two-cycle bubble
      do_reset(2);
      deq_mode = 1'b1;
      for (int q = 0; q < 4; q++) begin
         push(0, 1'b1, 32'(q));
         push(3, 1'b1, 32'('h300 + q));
      end
      push(1, 1'b0, 32'h100);
      base = cap_cnt;
      repeat (4) tick();
      push(1, 1'b0, 32'h101);
      push(1, 1'b1, 32'h102);
      wait_caps(base + 11, 60, "lock_timeout");
      for (int i = 0; i < 11; i++) begin
         chk($sformatf("lock_src[%0d]", i), 64'(cap_src[base+i]), 64'(e_src[i]));
         chk($sformatf("lock_data[%0d]", i), 64'(cap_data[base+i]), 64'(e_data[i]));
         chk($sformatf("lock_eop[%0d]", i), 64'(cap_eop[base+i]), 64'(e_eop[i]));
      end

      // Backpressure: output and both source buffers fill up
      do_reset(2);
      deq_mode = 1'b0;
      for (int q = 0; q < 6; q++) begin
         push(0, 1'b1, 32'(q));
         push(1, 1'b1, 32'('h100 + q));
      end
      repeat (10) tick();
      chk("bp_notEmpty", 64'(out_notEmpty), 64'd1);
      chk("bp_src", 64'(out_src), 64'd0);
      chk("bp_first", 64'(out_first), 64'd0);
      chk("bp_notFull", 64'(in_notFull), 64'hC);
      base = cap_cnt;
      deq_mode = 1'b1;
      wait_caps(base + 12, 60, "bp_timeout");
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("bp_src[%0d]", i), 64'(cap_src[base+i]), 64'(i % 2));
         chk($sformatf("bp_data[%0d]", i), 64'(cap_data[base+i]), 64'((i % 2) * 256 + i / 2));
      end

      // Reset in the middle of a source-0 packet
      do_reset(2);
      deq_mode = 1'b1;
      push(0, 1'b0, 32'h10);
      push(0, 1'b0, 32'h11);
      push(0, 1'b0, 32'h12);
      push(0, 1'b1, 32'h13);
      base = cap_cnt;
      wait_caps(base + 1, 20, "mid_first_timeout");
      chk("mid_first_data", 64'(cap_data[base]), 64'h10);
      do_reset(2);
      chk("mid_rst_notEmpty", 64'(out_notEmpty), 64'd0);
      chk("mid_rst_notFull", 64'(in_notFull), 64'hF);
      deq_mode = 1'b1;
      push(3, 1'b1, 32'h3AA);
      base = cap_cnt;
      wait_caps(base + 1, 10, "mid_grant_timeout");
      chk("mid_src", 64'(cap_src[base]), 64'd3);
      chk("mid_data", 64'(cap_data[base]), 64'h3AA);
      repeat (5) tick();
      chk("mid_no_stale", 64'(cap_cnt - base), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
